// File: rtl/ieee_754_exp_function_pkg.sv
// Shared types and constants for the e^x binary32 lookup block.
// The table is generated at elaboration from a wide fixed-point product chain.
package ieee_754_exp_function_pkg;

   typedef logic [31:0] word_t;

   localparam word_t       FP32_ONE      = 32'h3F80_0000;
   localparam word_t       FP32_POS_INF  = 32'h7F80_0000;
   localparam word_t       FP32_ZERO     = 32'h0000_0000;
   localparam int unsigned EXP_MAX_IN    = 88;
   localparam int unsigned EXP_LUT_DEPTH = EXP_MAX_IN + 1;

   // e * 2^128, far more precision than 88 chained multiplies can erode
   localparam logic [129:0] E_Q130 = 130'h2_B7E1_5162_8AED_2A6A_BF71_5880_9CF4_F3C7;
   localparam logic [127:0] E_MANT = 128'(E_Q130 >> 2);

   // Correctly rounded (RNE) binary32 of e^n, evaluated only as a constant.
   function automatic word_t exp_word(int unsigned n);
      logic [127:0] m;
      logic [255:0] p;
      logic [24:0]  sig;
      logic         up;
      int unsigned  ex;
      m  = {1'b1, 127'd0};
      ex = 0;
      for (int unsigned i = 0; i < n; i++) begin
         p = {128'd0, m} * {128'd0, E_MANT};
         if (p[255]) begin
            m  = p[255:128];
            ex = ex + 2;
         end else begin
            m  = p[254:127];
            ex = ex + 1;
         end
      end
      up  = m[103] & ((|m[102:0]) | m[104]);
      sig = {1'b0, m[127:104]} + {24'd0, up};
      if (sig[24]) begin
         sig = sig >> 1;
         ex  = ex + 1;
      end
      return {1'b0, 8'(ex + 127), sig[22:0]};
   endfunction

endpackage

// File: rtl/ieee_754_exp_function_if.sv
// Operand/result bundle between the requester and the e^x block.
interface ieee_754_exp_function_if;
   import ieee_754_exp_function_pkg::*;

   logic [7:0] x;
   word_t      exp_out;

   modport master (output x, input exp_out);
   modport slave  (input x, output exp_out);

endinterface

// File: rtl/exp_lut.sv
// Combinational table of e^idx in binary32 for idx 0..88; other indices give +INF.
module exp_lut
   import ieee_754_exp_function_pkg::*;
(
   input  logic [6:0] idx,
   output word_t      word
);

   word_t rom [EXP_LUT_DEPTH];

   for (genvar i = 0; i < EXP_LUT_DEPTH; i++) begin : g_rom
      localparam word_t Word = exp_word(i);
      assign rom[i] = Word;
   end

   always_comb begin
      word = FP32_POS_INF;
      if (idx <= 7'(EXP_MAX_IN)) begin
         word = rom[idx];
      end
   end

endmodule

// File: rtl/ieee_754_exp_function.sv
// Registered e^x for an 8-bit unsigned operand: table lookup, overflow to +INF.
module ieee_754_exp_function
   import ieee_754_exp_function_pkg::*;
(
   input logic                     clk,
   input logic                     rst,
   ieee_754_exp_function_if.slave  bus
);

   word_t lut_word;
   word_t exp_out_d;
   word_t exp_out_q;

   exp_lut u_exp_lut (
      .idx  (bus.x[6:0]),
      .word (lut_word)
   );

   // Full 8-bit compare: x[7] alone already means overflow
   always_comb begin
      exp_out_d = lut_word;
      if (bus.x > 8'(EXP_MAX_IN)) begin
         exp_out_d = FP32_POS_INF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         exp_out_q <= FP32_ZERO;
      end else begin
         exp_out_q <= exp_out_d;
      end
   end

   assign bus.exp_out = exp_out_q;

endmodule

// File: tb/tb_ieee_754_exp_function.sv
// Scoreboard bench for ieee_754_exp_function against a real-arithmetic e^x model.
module tb_ieee_754_exp_function;
   import ieee_754_exp_function_pkg::*;

   typedef struct {
      word_t      word;
      logic [7:0] x;
      logic       rst;
      logic       mono;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];
   exp_t mon_e;
   word_t prev_word;
   logic  have_prev = 1'b0;

   always #5 clk = ~clk;

   ieee_754_exp_function_if bus ();

   ieee_754_exp_function dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // e^v from the simulator's double exp, rounded to binary32 with RNE
   function automatic word_t ref_f(logic [7:0] v);
      logic [63:0] b;
      logic [24:0] s;
      logic        up;
      int          ex;
      if (v > 8'd88) return FP32_POS_INF;
      b  = $realtobits($exp(real'(v)));
      ex = int'(b[62:52]) - 1023 + 127;
      s  = {2'b01, b[51:29]};
      up = b[28] & ((|b[27:0]) | b[29]);
      s  = s + 25'(up);
      if (s[24]) begin
         s  = s >> 1;
         ex = ex + 1;
      end
      return {1'b0, 8'(ex), s[22:0]};
   endfunction

   task automatic step(input logic r, input logic [7:0] v, input logic mono,
                       input logic use_k, input word_t k);
      exp_t e;
      rst     = r;
      bus.x   = v;
      e.word  = r ? FP32_ZERO : (use_k ? k : ref_f(v));
      e.x     = v;
      e.rst   = r;
      e.mono  = mono;
      sb.push_back(e);
      @(posedge clk);
      #2;
   endtask

   // Monitor: one expected entry per edge, checked just after it and held to the negedge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            n_cmp++;
            if (bus.exp_out !== mon_e.word) begin
               n_bad++;
               $display("FAIL value x=%0d rst=%0b got=%h want=%h",
                        mon_e.x, mon_e.rst, bus.exp_out, mon_e.word);
            end
            if (!mon_e.rst) begin
               n_cmp++;
               if (bus.exp_out[31] || bus.exp_out == FP32_ZERO ||
                   (bus.exp_out[30:23] == 8'hFF && bus.exp_out[22:0] != 23'd0)) begin
                  n_bad++;
                  $display("FAIL sanity x=%0d got=%h want positive non-NaN non-zero",
                           mon_e.x, bus.exp_out);
               end
               if (mon_e.x == 8'd88) begin
                  n_cmp++;
                  if (bus.exp_out[31:23] != 9'h0FD) begin
                     n_bad++;
                     $display("FAIL exp88 got=%h want sign 0 exponent fd", bus.exp_out);
                  end
               end
               if (mon_e.x == 8'd15) begin
                  n_cmp++;
                  if (bus.exp_out[31:23] != 9'd148) begin
                     n_bad++;
                     $display("FAIL exp15 got=%h want biased exponent 148", bus.exp_out);
                  end
               end
            end
            if (mon_e.mono && !mon_e.rst && have_prev) begin
               n_cmp++;
               if (bus.exp_out < prev_word) begin
                  n_bad++;
                  $display("FAIL monotonic x=%0d got=%h want >= %h",
                           mon_e.x, bus.exp_out, prev_word);
               end
            end
            have_prev = mon_e.mono && !mon_e.rst;
            prev_word = bus.exp_out;
            @(negedge clk);
            n_cmp++;
            if (bus.exp_out !== mon_e.word) begin
               n_bad++;
               $display("FAIL hold x=%0d got=%h want=%h", mon_e.x, bus.exp_out, mon_e.word);
            end
         end
      end
   end

   initial begin
      int waited;
      bus.x = 8'd5;
      // Reset held with a live operand
      step(1'b1, 8'd5, 1'b0, 1'b0, FP32_ZERO);
      step(1'b1, 8'd5, 1'b0, 1'b0, FP32_ZERO);
      // Known small values
      step(1'b0, 8'd0,  1'b0, 1'b1, FP32_ONE);
      step(1'b0, 8'd1,  1'b0, 1'b1, 32'h402D_F854);
      step(1'b0, 8'd2,  1'b0, 1'b1, 32'h40EC_7326);
      step(1'b0, 8'd10, 1'b0, 1'b1, 32'h46AC_14EE);
      // Overflow boundary and saturation
      step(1'b0, 8'd88,  1'b0, 1'b0, FP32_ZERO);
      step(1'b0, 8'd89,  1'b0, 1'b1, FP32_POS_INF);
      step(1'b0, 8'd15,  1'b0, 1'b0, FP32_ZERO);
      step(1'b0, 8'd255, 1'b0, 1'b1, FP32_POS_INF);
      // Back-to-back sweep with a reset pulse in the middle
      for (int v = 0; v < 256; v++) begin
         if (v == 128) step(1'b1, 8'(v), 1'b1, 1'b0, FP32_ZERO);
         step(1'b0, 8'(v), 1'b1, 1'b0, FP32_ZERO);
      end
      // Random operands with occasional reset
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 19) == 0), 8'($urandom_range(0, 255)), 1'b0, 1'b0, FP32_ZERO);
      end
      rst = 1'b0;
      waited = 0;
      while (sb.size() != 0 && waited < 10) begin
         @(posedge clk);
         waited++;
      end
      repeat (2) @(posedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain got=%0d pending want=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ieee_754_exp_function.md
IEEE_754_EXP_FUNCTION -- requirements
Module: ieee_754_exp_function

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: x  input  8  unsigned integer operand, range 0..255.
REQ-005 Port: exp_out  output  32  IEEE 754 binary32 value of e^x, registered.
REQ-006 The block SHALL have no parameters.

Function
REQ-007 The block SHALL sample x on each rising clk edge with rst low and drive exp_out with f(x) from that same edge, a latency of 1 cycle.
REQ-008 exp_out SHALL hold its value between edges and SHALL have no combinational path from x.
REQ-009 For x in 0..88, f(x) SHALL be e^x correctly rounded to binary32 (round-to-nearest-even), with sign bit 0.
REQ-010 All in-range results SHALL be normal numbers: biased exponent 127..254, no denormals.
REQ-011 For x in 89..255, f(x) SHALL be +INF, 0x7F800000.
- Overflow boundary: e^88 ≈ 1.65e38 is finite; e^89 exceeds the binary32 maximum.
REQ-012 f(0) SHALL be exactly 0x3F800000 (1.0).
REQ-013 f SHALL be implemented as a constant lookup of 89 precomputed binary32 words indexed by x, plus an overflow compare (x > 88).
- No iterative or multi-cycle arithmetic.
REQ-014 The block SHALL never output NaN, a negative value or zero after the first post-reset sample.
REQ-015 If x changes every cycle, each output SHALL correspond to the x sampled one edge earlier, with no dropped or merged samples.

Reset
REQ-016 While rst is high at a rising edge, exp_out SHALL be loaded with 0x00000000 and x SHALL be ignored.
REQ-017 On the first edge with rst low, exp_out SHALL take f(x) for the x sampled at that edge.
REQ-018 Asserting rst mid-stream SHALL override any pending result on that edge.

Structure
REQ-019 A shared package SHALL hold these constants:
- FP32_ONE = 0x3F800000
- FP32_POS_INF = 0x7F800000
- FP32_ZERO = 0x00000000
- EXP_MAX_IN = 88
- the 32-bit word type
REQ-020 The table SHALL live in one combinational sub-module, exp_lut.
- Input: 7-bit index 0..88.
- Output: 32-bit binary32 word.
- Out-of-table indices return FP32_POS_INF.
REQ-021 The top level SHALL contain only the overflow compare, the result mux and the output register.

Verification
REQ-022 Reset: hold rst high for 2 cycles with x=5 -> exp_out = 0x00000000 throughout.
REQ-023 Small values: x=0, then 1, then 2, then 10 on consecutive cycles -> one cycle later each, exp_out = 0x3F800000, 0x402DF854, 0x40EC7326, 0x46AC14EE.
REQ-024 Overflow boundary: x=88 -> sign 0, exponent field 0xFD, finite; x=89 -> 0x7F800000.
REQ-025 Saturation: x=15 -> finite value ≈ 3.269e6, biased exponent 148; x=255 -> 0x7F800000.
REQ-026 Exhaustive sweep: x = 0..255 back-to-back -> every output matches a reference model with 1-cycle latency.
- Values are monotonic non-decreasing.
- Assert rst mid-sweep -> 0x00000000 on that edge, and a correct result on the next edge after release.
